uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer among NUM_REQ byte-stream requesters, e.g. trade reporter, debug/status logger and heartbeat.
- Round-robin arbitration at message granularity: once a requester wins, it holds the transmitter until it sends a byte flagged last, or until its lock times out.
- Drives the serializer's uart_tx_en/uart_tx_data and uses uart_tx_busy to pace bytes.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter sharing one uart_tx serializer
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            locked,
    output logic                            timeout_pulse
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LIMIT = CW'(LOCK_TIMEOUT);
    localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_LOCK
    } state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           ptr, ptr_nxt;
    logic [GW-1:0]           gid_nxt;
    logic                    locked_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;
    logic                    cap_last, last_nxt;
    logic [CW-1:0]           tcnt, tcnt_nxt;

    logic                    rr_found;
    logic [GW-1:0]           rr_idx;
    logic [GW-1:0]           cand;
    logic [GW-1:0]           sel;
    logic [PAYLOAD_BITS-1:0] sel_data;
    logic                    sel_last;
    logic                    sel_valid;
    logic [GW-1:0]           gid_inc;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        cand     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = GW'((int'(ptr) + k) % NUM_REQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Byte/last/valid of the requester that may be accepted this cycle (winner in IDLE, owner in LOCK).
    always_comb begin
        sel      = (state == S_IDLE) ? rr_idx : grant_id;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign sel_last  = req_last[sel];
    assign sel_valid = req_valid[sel];
    assign gid_inc   = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    // Next-state and output logic; ready is combinational so a byte transfers in the decision cycle.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gid_nxt       = grant_id;
        locked_nxt    = locked;
        data_nxt      = uart_tx_data;
        last_nxt      = cap_last;
        tcnt_nxt      = tcnt;
        req_ready     = '0;
        uart_tx_en    = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (rr_found && !uart_tx_busy) begin
                    req_ready[rr_idx] = 1'b1;
                    data_nxt          = sel_data;
                    last_nxt          = sel_last;
                    gid_nxt           = rr_idx;
                    state_nxt         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                uart_tx_en = 1'b1;
                state_nxt  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!uart_tx_busy) begin
                    if (cap_last) begin
                        locked_nxt = 1'b0;
                        ptr_nxt    = gid_inc;
                        state_nxt  = S_IDLE;
                    end else begin
                        locked_nxt = 1'b1;
                        tcnt_nxt   = '0;
                        state_nxt  = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (sel_valid && !uart_tx_busy) begin
                    req_ready[grant_id] = 1'b1;
                    data_nxt            = sel_data;
                    last_nxt            = sel_last;
                    state_nxt           = S_ISSUE;
                end else if (LOCK_TIMEOUT != 0 && tcnt == TMO_LIMIT) begin
                    timeout_pulse = 1'b1;
                    locked_nxt    = 1'b0;
                    ptr_nxt       = gid_inc;
                    state_nxt     = S_IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops everything immediately, even mid-frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            uart_tx_data <= '0;
            cap_last     <= 1'b0;
            tcnt         <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            grant_id     <= gid_nxt;
            locked       <= locked_nxt;
            uart_tx_data <= data_nxt;
            cap_last     <= last_nxt;
            tcnt         <= tcnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int PB    = 8;
    localparam int TMO   = 16;
    localparam int FRAME = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid;
    logic [NR*PB-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              uart_tx_en;
    logic [PB-1:0]     uart_tx_data;
    logic              uart_tx_busy;
    logic [1:0]        grant_id;
    logic              locked;
    logic              timeout_pulse;

    uart_tx_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .grant_id(grant_id), .locked(locked), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer model: busy for FRAME cycles starting the cycle after en is sampled.
    int bcnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)         bcnt <= 0;
        else if (uart_tx_en) bcnt <= FRAME;
        else if (bcnt != 0)  bcnt <= bcnt - 1;
    end
    assign uart_tx_busy = (bcnt != 0);

    typedef struct packed {
        logic [1:0]  gid;
        logic [7:0]  data;
        logic        lk;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic [1:0] g, input logic [7:0] d, input logic lk);
        exp_t e;
        e.gid = g; e.data = d; e.lk = lk;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Requester stimulus storage and driver.
    logic [7:0]    pd[NR][16];
    logic          pl[NR][16];
    int            pos[NR];
    int            n[NR];
    logic [NR-1:0] fire;

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        pd[r][n[r]] = d;
        pl[r][n[r]] = l;
        n[r]++;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) pos[i]++;
                if (pos[i] < n[i]) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*PB +: PB]  = pd[i][pos[i]];
                    req_last[i]           = pl[i][pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every en, plus pacing and ready invariants.
    int         rdy_cnt[NR];
    int         lk_cnt;
    int         tmo_cnt;
    logic [7:0] frame_data = '0;
    exp_t       got_e;

    always @(negedge clk) begin
        if (resetn) begin
            if (uart_tx_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got gid=%0d data=0x%0h, nothing expected", grant_id, uart_tx_data);
                end else begin
                    got_e = exp_q.pop_front();
                    if (grant_id !== got_e.gid || uart_tx_data !== got_e.data || locked !== got_e.lk) begin
                        miscompares++;
                        $display("FAIL sb_byte: got gid=%0d data=0x%0h locked=%0b expected gid=%0d data=0x%0h locked=%0b",
                                 grant_id, uart_tx_data, locked, got_e.gid, got_e.data, got_e.lk);
                    end
                end
                vectors++;
                if (uart_tx_busy) begin
                    miscompares++;
                    $display("FAIL en_while_busy: got en=1 busy=1 expected no en during frame");
                end
                frame_data = uart_tx_data;
            end
            if (uart_tx_busy) begin
                vectors++;
                if (uart_tx_data !== frame_data) begin
                    miscompares++;
                    $display("FAIL data_stable: got 0x%0h expected 0x%0h", uart_tx_data, frame_data);
                end
            end
            vectors++;
            if ($countones(req_ready) > 1 || (req_ready != '0 && uart_tx_busy)) begin
                miscompares++;
                $display("FAIL ready_rule: got ready=%b busy=%0b expected at most one and none while busy",
                         req_ready, uart_tx_busy);
            end
            for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
            if (locked) lk_cnt++;
            if (timeout_pulse) tmo_cnt++;
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
        lk_cnt  = 0;
        tmo_cnt = 0;
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    function automatic bit all_sent();
        bit s;
        s = 1'b1;
        for (int i = 0; i < NR; i++) if (pos[i] < n[i]) s = 1'b0;
        return s;
    endfunction

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !locked && !uart_tx_busy && !uart_tx_en && all_sent();
        end
        check({name, "_drain"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ready"},   32'(req_ready),     32'd0);
        check({name, "_en"},      32'(uart_tx_en),    32'd0);
        check({name, "_data"},    32'(uart_tx_data),  32'd0);
        check({name, "_gid"},     32'(grant_id),      32'd0);
        check({name, "_locked"},  32'(locked),        32'd0);
        check({name, "_timeout"}, 32'(timeout_pulse), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    int lat;
    bit seen;
    bit got;
    int lock_cyc;
    int pulse_cyc;

    initial begin
        resetn = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;

        // Contention from pointer 0: four single-byte messages go out 0,1,2,3.
        sync();
        clear_counts();
        for (int i = 0; i < NR; i++) begin
            add_byte(i, 8'h10 + 8'(i), 1'b1);
            push_exp(2'(i), 8'h10 + 8'(i), 1'b0);
        end
        wait_done("t2");
        for (int i = 0; i < NR; i++) check($sformatf("t2_ready_cnt%0d", i), 32'(rdy_cnt[i]), 32'd1);

        // Pointer wrapped back to 0: requester 0 beats requester 1.
        sync();
        add_byte(1, 8'h21, 1'b1);
        add_byte(0, 8'h20, 1'b1);
        push_exp(2'd0, 8'h20, 1'b0);
        push_exp(2'd1, 8'h21, 1'b0);
        wait_done("t2b");

        // Single request from requester 2: latency, single ready, no lock.
        sync();
        clear_counts();
        add_byte(2, 8'h41, 1'b1);
        push_exp(2'd2, 8'h41, 1'b0);
        lat = 0; seen = 1'b0; got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_valid[2]) seen = 1'b1;
            if (seen) lat++;
            if (uart_tx_en) got = 1'b1;
        end
        check("t1_latency", 32'(lat), 32'd2);
        wait_done("t1");
        check("t1_ready_cycles", 32'(rdy_cnt[2]), 32'd1);
        check("t1_locked_cycles", 32'(lk_cnt), 32'd0);
        check("t1_grant_id", 32'(grant_id), 32'd2);

        // Message lock: requester 1 holds the transmitter for three bytes while requester 0 waits.
        sync();
        clear_counts();
        add_byte(1, 8'hAA, 1'b0);
        add_byte(1, 8'hBB, 1'b0);
        add_byte(1, 8'hCC, 1'b1);
        push_exp(2'd1, 8'hAA, 1'b0);
        push_exp(2'd1, 8'hBB, 1'b1);
        push_exp(2'd1, 8'hCC, 1'b1);
        push_exp(2'd0, 8'h30, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = req_ready[1];
        end
        check("t3_first_accept", 32'(got), 32'd1);
        sync();
        add_byte(0, 8'h30, 1'b1);
        wait_done("t3");
        check("t3_locked_seen", 32'(lk_cnt != 0), 32'd1);
        check("t3_locked_final", 32'(locked), 32'd0);
        check("t3_no_timeout", 32'(tmo_cnt), 32'd0);

        // Timeout: requester 3 stalls after a non-last byte; requester 0 gets the next grant.
        sync();
        clear_counts();
        add_byte(3, 8'h99, 1'b0);
        push_exp(2'd3, 8'h99, 1'b0);
        push_exp(2'd0, 8'h31, 1'b0);
        got = 1'b0;
        lock_cyc = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = locked;
            lock_cyc = cyc;
        end
        check("t4_lock_entered", 32'(got), 32'd1);
        sync();
        add_byte(0, 8'h31, 1'b1);
        got = 1'b0;
        pulse_cyc = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = timeout_pulse;
            pulse_cyc = cyc;
        end
        check("t4_pulse_seen", 32'(got), 32'd1);
        check("t4_pulse_delay", 32'(pulse_cyc - lock_cyc), 32'(TMO));
        wait_done("t4");
        check("t4_pulse_count", 32'(tmo_cnt), 32'd1);

        // Reset while waiting for the frame to end, then arbitration restarts from pointer 0.
        sync();
        clear_counts();
        add_byte(2, 8'h5A, 1'b1);
        push_exp(2'd2, 8'h5A, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = uart_tx_en;
        end
        check("t6_en_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sync();
        add_byte(3, 8'h63, 1'b1);
        add_byte(0, 8'h60, 1'b1);
        push_exp(2'd0, 8'h60, 1'b0);
        push_exp(2'd3, 8'h63, 1'b0);
        wait_done("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
